// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: data-hazard detection, branch squash,
// memory-wait freeze, stall counter and memory-timeout flag. Optional: `FORWARDING_EN.
module pipeline_hazard_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int WAIT_LIMIT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             id_src1,
  input  logic                   id_src1_valid,
  input  logic [3:0]             id_src2,
  input  logic                   id_src2_valid,
  input  logic                   exe_wb_en,
  input  logic [3:0]             exe_dest,
  input  logic                   exe_mem_read,
  input  logic                   mem_wb_en,
  input  logic [3:0]             mem_dest,
  input  logic                   branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   freeze_front,
  output logic                   freeze_back,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   hazard,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   mem_timeout
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       mem_wait;
  logic       match1;
  logic       match2;
  logic       hazard_raw;

  assign mem_wait = mem_req & ~mem_ready;

`ifdef FORWARDING_EN
  // Forwarding covers every ALU result, so only a load still in EX can stall ID.
  assign match1 = exe_wb_en & exe_mem_read & (id_src1 == exe_dest);
  assign match2 = exe_wb_en & exe_mem_read & (id_src2 == exe_dest);
`else
  assign match1 = (exe_wb_en & (id_src1 == exe_dest)) | (mem_wb_en & (id_src1 == mem_dest));
  assign match2 = (exe_wb_en & (id_src2 == exe_dest)) | (mem_wb_en & (id_src2 == mem_dest));
`endif

  assign hazard_raw = (id_src1_valid & match1) | (id_src2_valid & match2);

  assign hazard       = ~rst & hazard_raw;
  assign freeze_back  = ~rst & mem_wait;
  assign freeze_front = ~rst & (mem_wait | (hazard_raw & ~branch_taken));
  assign flush_if_id  = ~rst & branch_taken & ~mem_wait;
  assign flush_id_ex  = ~rst & ~mem_wait & (branch_taken | hazard_raw);

  assign wait_inc = wait_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
            if (WAIT_LIM == 8'd1) mem_timeout <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready || !mem_req) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt < WAIT_LIM) begin
            wait_cnt <= wait_inc;
            if (wait_inc == WAIT_LIM) mem_timeout <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (freeze_front && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors queue expected outputs,
// an independent negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_src1_valid, id_src2_valid, exe_wb_en, exe_mem_read, mem_wb_en;
  logic       branch_taken, mem_req, mem_ready;
  logic       freeze_front, freeze_back, flush_if_id, flush_id_ex, hazard, mem_timeout;
  logic [3:0] stall_count;

  pipeline_hazard_ctrl #(.STALL_CNT_W(4), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src1_valid(id_src1_valid),
    .id_src2(id_src2), .id_src2_valid(id_src2_valid),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_front(freeze_front), .freeze_back(freeze_back),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .hazard(hazard), .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] s1;  logic s1v;
    logic [3:0] s2;  logic s2v;
    logic       ewb; logic [3:0] ed; logic emr;
    logic       mwb; logic [3:0] md;
    logic       br, mreq, mrdy;
    logic [9:0] exp;  // {ff, fb, fie, fee, hz, sc[3:0], to}
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] sbq[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         stim_done = 1'b0;

  task automatic v(input logic r, input logic [3:0] s1, input logic s1v,
                   input logic [3:0] s2, input logic s2v,
                   input logic ewb, input logic [3:0] ed, input logic emr,
                   input logic mwb, input logic [3:0] md,
                   input logic br, input logic mreq, input logic mrdy,
                   input logic ff, input logic fb, input logic fie, input logic fee,
                   input logic hz, input logic [3:0] sc, input logic to);
    vec_t t;
    t.r = r; t.s1 = s1; t.s1v = s1v; t.s2 = s2; t.s2v = s2v;
    t.ewb = ewb; t.ed = ed; t.emr = emr; t.mwb = mwb; t.md = md;
    t.br = br; t.mreq = mreq; t.mrdy = mrdy;
    t.exp = {ff, fb, fie, fee, hz, sc, to};
    vecs.push_back(t);
  endtask

  task automatic build_vectors();
`ifdef FORWARDING_EN
    //  r  s1 v  s2 v  ewb ed emr mwb md br rq rd   ff fb fie fee hz sc to
    v(1, 0, 0, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 5, 1, 1, 5, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);  // ALU result forwarded
    v(0, 0, 0, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0);  // load-use
    v(0, 0, 0, 5, 1, 0, 0, 0, 1, 5, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);  // load in MEM: clear
    v(0, 3, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 2, 0);
`else
    //  r  s1 v  s2 v  ewb ed emr mwb md br rq rd   ff fb fie fee hz sc to
    v(1, 3, 1, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);  // rst forces zeros
    v(0, 3, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0);  // EX RAW on src1
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
    v(0, 0, 0, 7, 1, 0, 0, 0, 1, 7, 0, 0, 0,   1, 0, 0, 1, 1, 1, 0);  // MEM RAW on src2
    v(0, 3, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2, 0);  // src not read
    v(0, 3, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2, 0);  // no writeback
    v(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 1, 1, 2, 0);  // r0 not special
    v(0, 3, 1, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0,   0, 0, 1, 1, 1, 3, 0);  // branch beats hazard
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 1, 0, 0, 0, 3, 0);  // wait holds branch
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 1, 0, 0, 0, 4, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 1, 0, 0, 0, 5, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1,   0, 0, 1, 1, 0, 6, 0);  // release: flush fires
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 6, 0);
    for (int i = 0; i < 6; i++)                                       // timeout after 4
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
        1, 1, 0, 0, 0, 4'(6 + i), (i >= 4) ? 1'b1 : 1'b0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 12, 1); // sticky
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 12, 1);
    v(0, 3, 1, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 1, 12, 1); // wait beats hazard
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 13, 1); // ~mem_req ends wait
    v(0, 3, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 13, 1);
    v(0, 3, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 14, 1);
    v(0, 3, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 15, 1); // saturate
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 15, 1);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 15, 1);
    v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 15, 1); // rst mid-wait
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)                                       // wait_cnt restarted
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 4'(i), 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 4, 1);
`endif
  endtask

  initial begin
    rst = 1'b1;
    id_src1 = '0; id_src1_valid = 1'b0; id_src2 = '0; id_src2_valid = 1'b0;
    exe_wb_en = 1'b0; exe_dest = '0; exe_mem_read = 1'b0;
    mem_wb_en = 1'b0; mem_dest = '0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    build_vectors();
    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      #1;
      rst = vecs[i].r;
      id_src1 = vecs[i].s1;  id_src1_valid = vecs[i].s1v;
      id_src2 = vecs[i].s2;  id_src2_valid = vecs[i].s2v;
      exe_wb_en = vecs[i].ewb; exe_dest = vecs[i].ed; exe_mem_read = vecs[i].emr;
      mem_wb_en = vecs[i].mwb; mem_dest = vecs[i].md;
      branch_taken = vecs[i].br; mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
      sbq.push_back(vecs[i].exp);
      @(posedge clk);
    end
    stim_done = 1'b1;
  end

  always @(negedge clk) begin
    logic [9:0] exp, act;
    if (sbq.size() > 0) begin
      exp = sbq.pop_front();
      act = {freeze_front, freeze_back, flush_if_id, flush_id_ex, hazard, stall_count, mem_timeout};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL vec%0d {ff,fb,fie,fee,hz,sc,to}: got %b %b %b %b %b %0d %b, want %b %b %b %b %b %0d %b",
                 n_vec - 1, act[9], act[8], act[7], act[6], act[5], act[4:1], act[0],
                 exp[9], exp[8], exp[7], exp[6], exp[5], exp[4:1], exp[0]);
      end
    end
  end

  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && sbq.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    if (budget >= 2000 || sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    if (n_vec != vecs.size()) begin
      n_err++;
      $display("FAIL count: got %0d checked, want %0d", n_vec, vecs.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It detects data hazards between the instruction in ID and the instructions in EX/MEM, and squashes wrong-path instructions on a taken branch. It also freezes the whole pipeline while the data memory is busy. Its outputs drive the freeze and flush inputs of the IF stage, the IF/ID register and the ID/EX register, and the freeze of the EX/MEM and MEM/WB registers. It also keeps a stall-cycle counter and a sticky memory-timeout flag.

## Interface
Parameters:
- STALL_CNT_W, 16, width of saturating stall-cycle counter
- WAIT_LIMIT, 255, consecutive memory-wait cycles before mem_timeout sets (1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_src1  in  4  Rn index of instruction in ID
- id_src1_valid  in  1  ID instruction reads id_src1
- id_src2  in  4  Rm/Rd-store index of instruction in ID
- id_src2_valid  in  1  ID instruction reads id_src2
- exe_wb_en  in  1  EX instruction writes a register
- exe_dest  in  4  EX destination index
- exe_mem_read  in  1  EX instruction is a load
- mem_wb_en  in  1  MEM instruction writes a register
- mem_dest  in  4  MEM destination index
- branch_taken  in  1  taken branch resolved in EX this cycle
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- freeze_front  out  1  hold PC and IF/ID
- freeze_back  out  1  hold ID/EX, EX/MEM, MEM/WB
- flush_if_id  out  1  zero IF/ID at next edge
- flush_id_ex  out  1  zero ID/EX at next edge (bubble)
- hazard  out  1  data hazard detected on ID instruction
- stall_count  out  STALL_CNT_W  cycles with freeze_front=1, saturating
- mem_timeout  out  1  sticky memory-timeout flag

## Operation
Terms:
- mem_wait = mem_req & ~mem_ready.
- match(x) = (x == exe_dest & exe_wb_en) or (x == mem_dest & mem_wb_en). The EX/MEM split of this term depends on FORWARDING_EN (see Configuration).

Combinational outputs (zero latency):
- hazard = (id_src1_valid & match(id_src1)) | (id_src2_valid & match(id_src2)).
- freeze_back = mem_wait.
- freeze_front = mem_wait | (hazard & ~branch_taken).
- flush_if_id = branch_taken & ~mem_wait.
- flush_id_ex = ~mem_wait & (branch_taken | hazard).
- All five outputs are forced to 0 while rst=1.

Priority:
- Memory wait beats branch and hazard. During a wait no flush fires; the branch stays in EX and flushes in the release cycle.
- A branch beats a hazard. The squashed ID instruction causes no stall.

FSM (state register, wait_cnt[7:0]):
- RUN: if mem_wait, go to MEM_WAIT and set wait_cnt to 1.
- MEM_WAIT: if mem_ready or ~mem_req, go to RUN and clear wait_cnt. Otherwise increment wait_cnt, saturating at WAIT_LIMIT.
- mem_timeout sets at the edge where wait_cnt reaches WAIT_LIMIT. It holds until rst.

Counters:
- stall_count increments at each edge where freeze_front=1.
- It holds at 2^STALL_CNT_W-1 once reached.

Reset (synchronous): state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0.

## Timing
- Flush and freeze act at the same edge they are evaluated. The stage registers sample them on that edge.
- Load-use stall lasts exactly 1 cycle (forwarding on): the next cycle the load is in MEM, so match clears.
- RAW stall (forwarding off) lasts 1–2 cycles until the producer leaves MEM.
- A memory wait of N cycles with mem_ready on cycle N+1 freezes the pipeline for N cycles. The pipeline advances in the mem_ready cycle.
- stall_count and mem_timeout update one edge after the causing cycle.
- rst asserted mid-wait: the FSM returns to RUN at the next edge and outputs read 0 during rst. After release, outputs follow the inputs.
- Register 0 is not special. Index match is purely on 4-bit equality.

## Configuration
- FORWARDING_EN defined: match() uses only (x == exe_dest & exe_wb_en & exe_mem_read). MEM-stage terms are ignored, because the forwarding unit covers them.
- FORWARDING_EN undefined: full match() on the EX and MEM destinations, as defined above.

## Test plan
- No forwarding: ID src1=3 valid, EX wb_en=1 dest=3 → hazard=1, freeze_front=1, flush_id_ex=1, flush_if_id=0. stall_count goes 0→1.
- FORWARDING_EN: EX dest=5 wb_en=1 exe_mem_read=0, src2=5 → hazard=0. Same with exe_mem_read=1 → exactly 1 stall cycle.
- branch_taken=1 with a hazard active → flush_if_id=1, flush_id_ex=1, freeze_front=0. stall_count unchanged.
- mem_req=1, mem_ready=0 for 3 cycles, then 1 → freeze_back=1 and freeze_front=1 for 3 cycles, 0 on the 4th. stall_count=3. With branch_taken=1 throughout, the flushes fire only on the 4th cycle.
- WAIT_LIMIT=4, mem_wait held 6 cycles → mem_timeout=1 from the cycle after the 4th wait cycle. It stays 1 after mem_ready until rst.
- rst=1 during MEM_WAIT with mem_req=1, mem_ready=0 → all freeze/flush outputs 0. Next cycle: stall_count=0, mem_timeout=0, FSM=RUN.
